// File: rtl/sha256_msg_schedule_if.sv
// Valid/ready bundle between the message source, the W[t] schedule and the round logic.
// The schedule uses the master view; the source/round-logic side uses slave.
interface sha256_msg_schedule_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [5:0]  w_index;
    logic        w_last;

    modport master (
        input  in_valid, in_data, w_ready,
        output in_ready, w_valid, w_data, w_index, w_last
    );

    modport slave (
        output in_valid, in_data, w_ready,
        input  in_ready, w_valid, w_data, w_index, w_last
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads W[0..15], expands W[16..ROUNDS-1], one word per cycle.
// Optional block counter port blk_count is enabled by defining SHA256_SCHED_CNT_EN.
module sha256_s0 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module sha256_s1 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module sha256_msg_schedule #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    sha256_msg_schedule_if.master    bus
`ifdef SHA256_SCHED_CNT_EN
    ,
    output logic [CNT_W-1:0]         blk_count
`endif
);
    typedef enum logic [0:0] {StLoad, StExpand} state_e;

    localparam logic [5:0] LastIdx = 6'(ROUNDS - 1);

    state_e      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic        wv_q, wv_d;
    logic [31:0] wd_q, wd_d;
    logic [5:0]  wi_q, wi_d;
    logic        wl_q, wl_d;

    logic        out_free;
    logic        push;
    logic        in_ready;
    logic [31:0] new_word;
    logic [31:0] s0_out, s1_out;

    // win_q[15] is W[t-1], win_q[0] is W[t-16].
    sha256_s0 u_s0 (.x(win_q[1]),  .y(s0_out));
    sha256_s1 u_s1 (.x(win_q[14]), .y(s1_out));

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        win_d    = win_q;
        wv_d     = wv_q & ~bus.w_ready;
        wd_d     = wd_q;
        wi_d     = wi_q;
        wl_d     = wl_q;
        in_ready = 1'b0;
        push     = 1'b0;
        new_word = bus.in_data;
        out_free = ~wv_q | bus.w_ready;

        unique case (state_q)
            StLoad: begin
                in_ready = out_free;
                push     = bus.in_valid & out_free;
                if (push && t_q == 6'd15) state_d = StExpand;
            end
            StExpand: begin
                push     = out_free;
                new_word = s1_out + win_q[9] + s0_out + win_q[0];
                if (push && t_q == LastIdx) state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase

        if (push) begin
            wv_d = 1'b1;
            wd_d = new_word;
            wi_d = t_q;
            wl_d = (t_q == LastIdx);
            t_d  = (t_q == LastIdx) ? 6'd0 : t_q + 6'd1;
            for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
            win_d[15] = new_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            t_q     <= '0;
            wv_q    <= 1'b0;
            wd_q    <= '0;
            wi_q    <= '0;
            wl_q    <= 1'b0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            wv_q    <= wv_d;
            wd_q    <= wd_d;
            wi_q    <= wi_d;
            wl_q    <= wl_d;
            win_q   <= win_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.w_valid  = wv_q;
    assign bus.w_data   = wd_q;
    assign bus.w_index  = wi_q;
    assign bus.w_last   = wl_q;

`ifdef SHA256_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (wv_q && bus.w_ready && wl_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign blk_count = cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: abc block, backpressure, back-to-back, mid-block reset.
// Define SHA256_SCHED_CNT_EN to also check blk_count with CNT_W=2.
module tb_sha256_msg_schedule;
    localparam int ROUNDS = 64;
    localparam int CNT_W  = 2;

    typedef logic [31:0] blk_t [16];

    logic clk;
    logic rst;
    sha256_msg_schedule_if bus ();
`ifdef SHA256_SCHED_CNT_EN
    logic [CNT_W-1:0] blk_count;
`endif

    sha256_msg_schedule #(
        .ROUNDS(ROUNDS),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef SHA256_SCHED_CNT_EN
        ,
        .blk_count(blk_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic        rand_ready = 1'b0;
    logic        full_rate  = 1'b0;
    logic        b2b        = 1'b0;
    int          b2b_base   = 0;

    int          mon_t = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          blk_done = 0;
    int          exp_cnt = 0;
    logic        cnt_chk = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] held_d;
    logic [5:0]  held_i;
    logic [31:0] seen_w [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic push_model(input blk_t m);
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
        for (int t = 0; t < ROUNDS; t++) exp_q.push_back(w[t]);
    endtask

    task automatic feed_block(input blk_t m, input logic gaps);
        int   tries;
        logic acc;
        push_model(m);
        for (int i = 0; i < 16; i++) begin
            tries = 0;
            do begin
                @(posedge clk);
                #2;
                if (gaps && $urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = $urandom;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = m[i];
                end
                @(negedge clk);
                acc = bus.in_valid && bus.in_ready;
                tries++;
                if (tries > 500) begin
                    $display("FAIL feed_timeout: word %0d not accepted, required accept", i);
                    $fatal(1, "input handshake stuck");
                end
            end while (!acc);
        end
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_w_valid", 32'(bus.w_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_w_index", 32'(bus.w_index), 32'd0);
`ifdef SHA256_SCHED_CNT_EN
        check("rst_blk_count", 32'(blk_count), 32'd0);
`endif
    endtask

    task automatic check_abc_head(input string tag);
        check({tag, "_w16"}, seen_w[16], 32'h61626380);
        check({tag, "_w17"}, seen_w[17], 32'h000F0000);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: a word is consumed at the posedge following a negedge that sees valid&ready.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mon_t      = 0;
                prev_stall = 1'b0;
                exp_cnt    = 0;
                cnt_chk    = 1'b0;
            end else begin
`ifdef SHA256_SCHED_CNT_EN
                if (cnt_chk) begin
                    check("blk_count", 32'(blk_count), 32'(exp_cnt));
                    cnt_chk = 1'b0;
                end
`endif
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.w_valid), 32'd1);
                    check("stall_data", bus.w_data, held_d);
                    check("stall_index", 32'(bus.w_index), 32'(held_i));
                end
                if (bus.w_valid && bus.w_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", 32'(bus.w_index), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("w_data", bus.w_data, e);
                    end
                    check("w_index", 32'(bus.w_index), 32'(mon_t));
                    check("w_last", 32'(bus.w_last), 32'(mon_t == ROUNDS - 1));
                    seen_w[mon_t] = bus.w_data;
                    if (mon_t == 0) begin
                        if (b2b && blk_done > b2b_base) check("b2b_gap", 32'(cyc), 32'(last_cyc + 1));
                        first_cyc = cyc;
                    end
                    if (mon_t == ROUNDS - 1) begin
                        if (full_rate) check("burst_len", 32'(cyc - first_cyc), 32'(ROUNDS - 1));
                        last_cyc = cyc;
                        blk_done++;
                        exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
                        cnt_chk  = 1'b1;
                    end
                    mon_t = (mon_t + 1) % ROUNDS;
                end
                prev_stall = bus.w_valid && !bus.w_ready;
                held_d     = bus.w_data;
                held_i     = bus.w_index;
            end
        end
    end

    initial begin
        blk_t abc;
        blk_t m2;
        int   n;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.w_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            abc[i] = '0;
            m2[i]  = 32'h9E3779B9 * 32'(i + 1) ^ 32'h5A5A0000;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        do_reset();

        // abc block at full rate
        full_rate = 1'b1;
        feed_block(abc, 1'b0);
        wait_drain();
        check_abc_head("abc");

        // random backpressure and input gaps
        full_rate  = 1'b0;
        rand_ready = 1'b1;
        feed_block(abc, 1'b1);
        wait_drain();
        check_abc_head("bp");
        rand_ready = 1'b0;

        // back-to-back blocks, different contents
        full_rate = 1'b1;
        b2b_base  = blk_done;
        b2b       = 1'b1;
        feed_block(abc, 1'b0);
        feed_block(m2, 1'b0);
        wait_drain();
        b2b = 1'b0;

        // reset while t=30 is being presented, then a fresh block
        feed_block(abc, 1'b0);
        n = 0;
        while (mon_t != 30 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_t30", 32'(mon_t), 32'd30);
        do_reset();
        feed_block(abc, 1'b0);
        wait_drain();
        check_abc_head("post_rst");

        // four more blocks: counter sequence after reset ends 1,2,3,0,1
        for (int b = 0; b < 4; b++) begin
            feed_block((b % 2 == 0) ? m2 : abc, 1'b0);
            wait_drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
